// File: rtl/async_trigger_arbiter.sv
// Per-channel end-of-trigger capture, pending flags with drop counting, and a
// round-robin valid/ready serializer that reports the granted channel index.
module async_trigger_arbiter #(
  parameter int NUM_CH = 8,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] async_trig,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic              trig_valid,
  output logic [CH_W-1:0]   trig_ch,
  input  logic              trig_ready,
  output logic [NUM_CH-1:0] pending,
  output logic [CNT_W-1:0]  drop_count
);

  typedef enum logic {IDLE, OFFER} state_t;

  localparam int SUM_W = CNT_W + 6;
  localparam logic [SUM_W-1:0]  CNT_MAX   = SUM_W'({CNT_W{1'b1}});
  localparam logic [CH_W:0]     NUM_CH_W  = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

  state_t             state_q, state_d;
  logic               valid_q, valid_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [CH_W-1:0]    rr_q, rr_d;
  logic [NUM_CH-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic [NUM_CH-1:0]  sync_d_q, sync_s_q;
  logic [NUM_CH-1:0]  ev, hit, offered, drop_vec;
  logic               ack;

  assign ack = (state_q == OFFER) & trig_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // s pulses for one cycle on the first low sample after a high sample.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync_d_q[gi] <= 1'b0;
          sync_s_q[gi] <= 1'b0;
        end else if (async_trig[gi]) begin
          sync_d_q[gi] <= 1'b1;
          sync_s_q[gi] <= 1'b0;
        end else begin
          sync_s_q[gi] <= sync_d_q[gi];
          sync_d_q[gi] <= 1'b0;
        end
      end

      assign ev[gi]       = sync_s_q[gi] & ch_enable[gi];
      assign offered[gi]  = (state_q == OFFER) & (ch_q == CH_W'(gi));
      assign hit[gi]      = ack & (ch_q == CH_W'(gi));
      assign drop_vec[gi] = ev[gi] & pending_q[gi] & ~hit[gi];

      // A live offer keeps its flag even when the channel is disabled.
      assign pending_d[gi] = (~ch_enable[gi] & ~offered[gi]) ? 1'b0 :
                             ev[gi]                          ? 1'b1 :
                             hit[gi]                         ? 1'b0 :
                                                               pending_q[gi];
    end
  endgenerate

  always_comb begin
    logic [SUM_W-1:0] total;
    total = SUM_W'(drop_q);
    for (int i = 0; i < NUM_CH; i++) begin
      total = total + SUM_W'(drop_vec[i]);
    end
    drop_d = (total > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : total[CNT_W-1:0];
  end

  always_comb begin
    logic            found;
    logic [CH_W-1:0] pick;
    logic [CH_W:0]   idx;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, rr_q} + (CH_W+1)'(k);
      if (idx >= NUM_CH_W) idx = idx - NUM_CH_W;
      if (!found && pending_q[idx[CH_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[CH_W-1:0];
      end
    end

    state_d = state_q;
    valid_d = valid_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          ch_d    = pick;
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (trig_ready) begin
          valid_d = 1'b0;
          rr_d    = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      ch_q      <= '0;
      rr_q      <= '0;
      pending_q <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      ch_q      <= ch_d;
      rr_q      <= rr_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  assign trig_valid = valid_q;
  assign trig_ch    = ch_q;
  assign pending    = pending_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_async_trigger_arbiter.sv
// Directed bench for async_trigger_arbiter: latency, round-robin order,
// drops, ack/retrigger overlap, disable, reset mid-offer and saturation.
module tb_async_trigger_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] async_trig;
  logic [7:0] ch_enable;
  logic       trig_valid;
  logic [2:0] trig_ch;
  logic       trig_ready;
  logic [7:0] pending;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;

  async_trigger_arbiter #(.NUM_CH(8), .CH_W(3), .CNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .async_trig (async_trig),
    .ch_enable  (ch_enable),
    .trig_valid (trig_valid),
    .trig_ch    (trig_ch),
    .trig_ready (trig_ready),
    .pending    (pending),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // High across one edge, then low; returns just after the first low-sample edge.
  task automatic pulse(input logic [7:0] mask);
    async_trig = mask;
    tick();
    async_trig = '0;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    async_trig = '0;
    ch_enable  = 8'hFF;
    trig_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(trig_valid), 0);
    check_eq("rst_ch", 32'(trig_ch), 0);
    check_eq("rst_pending", 32'(pending), 0);
    check_eq("rst_drop", 32'(drop_count), 0);
    reset_n = 1'b1;
    tick();

    // ch 3 high two cycles, nominal latency
    async_trig[3] = 1'b1;
    tick();
    tick();
    async_trig[3] = 1'b0;
    tick();
    check_eq("t2_e1_pending", 32'(pending), 0);
    tick();
    check_eq("t2_e2_pending", 32'(pending), 32'h08);
    check_eq("t2_e2_valid", 32'(trig_valid), 0);
    tick();
    check_eq("t2_e3_valid", 32'(trig_valid), 1);
    check_eq("t2_e3_ch", 32'(trig_ch), 3);
    tick();
    check_eq("t2_e4_valid", 32'(trig_valid), 0);
    check_eq("t2_e4_pending", 32'(pending), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t2_single", 32'(trig_valid), 0);
    end

    // reset while an offer is outstanding
    trig_ready = 1'b0;
    pulse(8'h04);
    tick();
    tick();
    check_eq("t1_offer_valid", 32'(trig_valid), 1);
    check_eq("t1_offer_ch", 32'(trig_ch), 2);
    pulse(8'h04);
    tick();
    check_eq("t1_drop", 32'(drop_count), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t1_async_valid", 32'(trig_valid), 0);
    check_eq("t1_async_pending", 32'(pending), 0);
    check_eq("t1_async_drop", 32'(drop_count), 0);
    tick();
    reset_n    = 1'b1;
    trig_ready = 1'b1;
    pulse(8'h04);
    check_eq("t1_lat_e1", 32'(pending), 0);
    tick();
    check_eq("t1_lat_e2", 32'(pending), 32'h04);
    check_eq("t1_lat_e2_valid", 32'(trig_valid), 0);
    tick();
    check_eq("t1_lat_e3_valid", 32'(trig_valid), 1);
    check_eq("t1_lat_e3_ch", 32'(trig_ch), 2);
    tick();
    check_eq("t1_lat_e4_valid", 32'(trig_valid), 0);

    // round robin 0,2,5 then 0,5
    do_reset();
    pulse(8'h25);
    tick();
    check_eq("t3_pending", 32'(pending), 32'h25);
    tick();
    check_eq("t3_g0_valid", 32'(trig_valid), 1);
    check_eq("t3_g0_ch", 32'(trig_ch), 0);
    tick();
    check_eq("t3_gap0", 32'(trig_valid), 0);
    check_eq("t3_gap0_pending", 32'(pending), 32'h24);
    tick();
    check_eq("t3_g1_ch", 32'(trig_ch), 2);
    check_eq("t3_g1_valid", 32'(trig_valid), 1);
    tick();
    check_eq("t3_gap1", 32'(trig_valid), 0);
    tick();
    check_eq("t3_g2_ch", 32'(trig_ch), 5);
    check_eq("t3_g2_valid", 32'(trig_valid), 1);
    tick();
    check_eq("t3_done_pending", 32'(pending), 0);
    pulse(8'h21);
    tick();
    tick();
    check_eq("t3_r0_ch", 32'(trig_ch), 0);
    tick();
    tick();
    check_eq("t3_r1_ch", 32'(trig_ch), 5);
    check_eq("t3_r1_valid", 32'(trig_valid), 1);
    tick();

    // ch 1: one drop while offered, then retrigger coinciding with ack
    trig_ready = 1'b0;
    pulse(8'h02);
    tick();
    tick();
    check_eq("t4_offer_ch", 32'(trig_ch), 1);
    pulse(8'h02);
    tick();
    check_eq("t4_drop", 32'(drop_count), 1);
    check_eq("t4_pending", 32'(pending), 32'h02);
    pulse(8'h02);
    trig_ready = 1'b1;
    tick();
    check_eq("t4_ack_valid", 32'(trig_valid), 0);
    check_eq("t4_ack_pending", 32'(pending), 32'h02);
    check_eq("t4_ack_drop", 32'(drop_count), 1);
    tick();
    check_eq("t4_regrant_ch", 32'(trig_ch), 1);
    check_eq("t4_regrant_valid", 32'(trig_valid), 1);
    tick();
    check_eq("t4_end_pending", 32'(pending), 0);

    // ch 4: new event exactly on the ack edge
    trig_ready = 1'b0;
    pulse(8'h10);
    tick();
    tick();
    check_eq("t5_offer_ch", 32'(trig_ch), 4);
    pulse(8'h10);
    trig_ready = 1'b1;
    tick();
    check_eq("t5_ack_pending", 32'(pending), 32'h10);
    check_eq("t5_ack_drop", 32'(drop_count), 1);
    tick();
    check_eq("t5_regrant_ch", 32'(trig_ch), 4);
    check_eq("t5_regrant_valid", 32'(trig_valid), 1);
    tick();
    check_eq("t5_end_valid", 32'(trig_valid), 0);

    // ch 6 disabled while pending behind an offer of ch 0
    trig_ready = 1'b0;
    pulse(8'h01);
    tick();
    tick();
    check_eq("t6_offer_ch", 32'(trig_ch), 0);
    pulse(8'h40);
    tick();
    check_eq("t6_pending", 32'(pending), 32'h41);
    ch_enable[6] = 1'b0;
    tick();
    check_eq("t6_disable_pending", 32'(pending), 32'h01);
    check_eq("t6_offer_held", 32'(trig_valid), 1);
    trig_ready = 1'b1;
    tick();
    check_eq("t6_ack_pending", 32'(pending), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t6_no_offer", 32'(trig_valid), 0);
    end
    ch_enable = 8'hFF;

    // multi-channel drops and saturation
    do_reset();
    trig_ready = 1'b0;
    pulse(8'hFF);
    tick();
    check_eq("sat_pending", 32'(pending), 32'hFF);
    pulse(8'hFF);
    tick();
    check_eq("sat_drop8", 32'(drop_count), 8);
    repeat (30) pulse(8'hFF);
    tick();
    check_eq("sat_drop248", 32'(drop_count), 248);
    pulse(8'hFF);
    tick();
    check_eq("sat_clip", 32'(drop_count), 255);
    repeat (7) pulse(8'hFF);
    tick();
    check_eq("sat_hold", 32'(drop_count), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
